// File: rtl/regwb_scoreboard_pkg.sv
// Shared definitions for the DE-stage hazard view: register address width,
// register count and write-enable helpers.
package regwb_scoreboard_pkg;

   localparam int unsigned reg_aw_c = 5;
   localparam int unsigned nreg_c   = 32;
   localparam logic [reg_aw_c-1:0] reg0_c = '0;

   function automatic logic wen_any(input logic [3:0] wen);
      return |wen;
   endfunction

endpackage

// File: rtl/regwb_scoreboard_sb_entry.sv
// One tracked register: pending-write counter plus youngest-writer load bit.
module sb_entry #(
   parameter int unsigned CNT_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   input  logic flush,
   input  logic is_load,
   output logic pending,
   output logic load,
   output logic sat,
   output logic unf
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_q, ld_d;

   always_comb begin
      cnt_d = cnt_q;
      ld_d  = ld_q;
      sat   = 1'b0;
      // A retire with nothing pending is an error even if a flush hides it.
      unf   = dec & ~(inc & ~flush) & (cnt_q == '0);
      if (flush) begin
         cnt_d = '0;
         ld_d  = 1'b0;
      end else if (inc && dec) begin
         ld_d = is_load;
      end else if (inc) begin
         ld_d = is_load;
         if (cnt_q == CntMax) sat = 1'b1;
         else cnt_d = cnt_q + CntOne;
      end else if (dec && cnt_q != '0) begin
         cnt_d = cnt_q - CntOne;
         if (cnt_q == CntOne) ld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ld_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ld_q  <= ld_d;
      end
   end

   assign pending = (cnt_q != '0);
   assign load    = ld_q;

endmodule

// File: rtl/regwb_scoreboard.sv
// Pending-write scoreboard: tracks DE->EX issued writes until WB retires them,
// and exposes pending/load status for the two DE read ports plus divider busy.
module regwb_scoreboard
   import regwb_scoreboard_pkg::*;
#(
   parameter int unsigned NREG  = nreg_c,
   parameter int unsigned CNT_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic [reg_aw_c-1:0] issue_waddr,
   input  logic [3:0]          issue_wen,
   input  logic                issue_is_load,
   input  logic                issue_is_div,
   input  logic                retire_valid,
   input  logic [reg_aw_c-1:0] retire_waddr,
   input  logic [3:0]          retire_wen,
   input  logic                div_done,
   input  logic                flush,
   input  logic [reg_aw_c-1:0] rs_addr,
   input  logic [reg_aw_c-1:0] rt_addr,
   output logic                rs_pending,
   output logic                rt_pending,
   output logic                rs_load,
   output logic                rt_load,
   output logic                div_busy,
   output logic                sb_err
);

   logic issue_hit, retire_hit;
   logic [NREG-1:0] pend, ldv, sat_v, unf_v;
   logic div_busy_q, div_busy_d;
   logic sb_err_q, sb_err_d;

   assign issue_hit  = issue_valid & wen_any(issue_wen) & (issue_waddr != reg0_c);
   assign retire_hit = retire_valid & wen_any(retire_wen) & (retire_waddr != reg0_c);

   // Register 0 is hardwired and never tracked.
   assign pend[0]  = 1'b0;
   assign ldv[0]   = 1'b0;
   assign sat_v[0] = 1'b0;
   assign unf_v[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_entry
      sb_entry #(
         .CNT_W(CNT_W)
      ) u_entry (
         .clk    (clk),
         .rst    (rst),
         .inc    (issue_hit & (issue_waddr == reg_aw_c'(r))),
         .dec    (retire_hit & (retire_waddr == reg_aw_c'(r))),
         .flush  (flush),
         .is_load(issue_is_load),
         .pending(pend[r]),
         .load   (ldv[r]),
         .sat    (sat_v[r]),
         .unf    (unf_v[r])
      );
   end

   always_comb begin
      div_busy_d = div_busy_q;
      if (flush) div_busy_d = 1'b0;
      else if (issue_valid && issue_is_div) div_busy_d = 1'b1;
      else if (div_done) div_busy_d = 1'b0;
      sb_err_d = sb_err_q | (|sat_v) | (|unf_v);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_busy_q <= 1'b0;
         sb_err_q   <= 1'b0;
      end else begin
         div_busy_q <= div_busy_d;
         sb_err_q   <= sb_err_d;
      end
   end

   assign rs_pending = (rs_addr != reg0_c) & pend[rs_addr];
   assign rt_pending = (rt_addr != reg0_c) & pend[rt_addr];
   assign rs_load    = rs_pending & ldv[rs_addr];
   assign rt_load    = rt_pending & ldv[rt_addr];
   assign div_busy   = div_busy_q;
   assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_regwb_scoreboard.sv
// Table-driven bench for regwb_scoreboard; expected outputs travel through a
// scoreboard queue from drive time to sample time.
module tb_regwb_scoreboard;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       issue_valid = 1'b0, issue_is_load = 1'b0, issue_is_div = 1'b0;
   logic [4:0] issue_waddr = '0, retire_waddr = '0, rs_addr = '0, rt_addr = '0;
   logic [3:0] issue_wen = '0, retire_wen = '0;
   logic       retire_valid = 1'b0, div_done = 1'b0, flush = 1'b0;
   logic       rs_pending, rt_pending, rs_load, rt_load, div_busy, sb_err;

   always #5 clk = ~clk;

   regwb_scoreboard #(
      .NREG (32),
      .CNT_W(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_waddr  (issue_waddr),
      .issue_wen    (issue_wen),
      .issue_is_load(issue_is_load),
      .issue_is_div (issue_is_div),
      .retire_valid (retire_valid),
      .retire_waddr (retire_waddr),
      .retire_wen   (retire_wen),
      .div_done     (div_done),
      .flush        (flush),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_pending   (rs_pending),
      .rt_pending   (rt_pending),
      .rs_load      (rs_load),
      .rt_load      (rt_load),
      .div_busy     (div_busy),
      .sb_err       (sb_err)
   );

   typedef struct {
      string      name;
      logic       iv;
      logic [4:0] iwa;
      logic [3:0] iwen;
      logic       ild, idiv, rv;
      logic [4:0] rwa;
      logic       dd, fl;
      logic [4:0] rs, rt;
      logic [5:0] exp;  // {rs_p, rs_l, rt_p, rt_l, div_busy, sb_err}
   } vec_t;

   typedef struct {
      string      name;
      logic [5:0] exp;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   checks = 0;
   int   passes = 0;

   function automatic vec_t mk(string n, logic iv, logic [4:0] iwa, logic [3:0] iwen,
                               logic ild, logic idiv, logic rv, logic [4:0] rwa,
                               logic dd, logic fl, logic [4:0] rs, logic [4:0] rt,
                               logic [5:0] exp);
      vec_t v;
      v.name = n; v.iv = iv; v.iwa = iwa; v.iwen = iwen; v.ild = ild; v.idiv = idiv;
      v.rv = rv; v.rwa = rwa; v.dd = dd; v.fl = fl; v.rs = rs; v.rt = rt; v.exp = exp;
      return v;
   endfunction

   task automatic check_now();
      sb_t        e;
      logic [5:0] got;
      got = {rs_pending, rs_load, rt_pending, rt_load, div_busy, sb_err};
      checks++;
      if (sbq.size() == 0) begin
         $display("FAIL scoreboard_empty got=%b required=an expected entry", got);
         return;
      end
      e = sbq.pop_front();
      if (got === e.exp) passes++;
      else $display("FAIL %s got=%b required=%b", e.name, got, e.exp);
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      issue_valid = v.iv; issue_waddr = v.iwa; issue_wen = v.iwen;
      issue_is_load = v.ild; issue_is_div = v.idiv;
      retire_valid = v.rv; retire_waddr = v.rwa; retire_wen = v.rv ? 4'hF : 4'h0;
      div_done = v.dd; flush = v.fl; rs_addr = v.rs; rt_addr = v.rt;
      sbq.push_back('{name: v.name, exp: v.exp});
      @(posedge clk);
      #1;
      check_now();
      issue_valid = 1'b0; retire_valid = 1'b0; div_done = 1'b0; flush = 1'b0;
      issue_is_div = 1'b0;
   endtask

   initial begin
      tbl.push_back(mk("issue_r5",        1, 5, 4'hF, 0, 0, 0, 0, 0, 0, 5, 0, 6'b100000));
      tbl.push_back(mk("retire_r5",       0, 0, 4'h0, 0, 0, 1, 5, 0, 0, 5, 0, 6'b000000));
      tbl.push_back(mk("load_r8",         1, 8, 4'hF, 1, 0, 0, 0, 0, 0, 0, 8, 6'b001100));
      tbl.push_back(mk("alu_r8_cnt2",     1, 8, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8, 6'b001000));
      tbl.push_back(mk("retire_r8_cnt1",  0, 0, 4'h0, 0, 0, 1, 8, 0, 0, 0, 8, 6'b001000));
      tbl.push_back(mk("retire_r8_cnt0",  0, 0, 4'h0, 0, 0, 1, 8, 0, 0, 0, 8, 6'b000000));
      tbl.push_back(mk("issue_r3",        1, 3, 4'hF, 0, 0, 0, 0, 0, 0, 3, 0, 6'b100000));
      tbl.push_back(mk("same_cyc_r3",     1, 3, 4'hF, 1, 0, 1, 3, 0, 0, 3, 0, 6'b110000));
      tbl.push_back(mk("retire_r3",       0, 0, 4'h0, 0, 0, 1, 3, 0, 0, 3, 0, 6'b000000));
      tbl.push_back(mk("issue_r0",        1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 7, 6'b000000));
      tbl.push_back(mk("issue_r7_wen0",   1, 7, 4'h0, 0, 0, 0, 0, 0, 0, 7, 0, 6'b000000));
      tbl.push_back(mk("r9_issue1",       1, 9, 4'h1, 0, 0, 0, 0, 0, 0, 9, 0, 6'b100000));
      tbl.push_back(mk("r9_issue2",       1, 9, 4'h2, 0, 0, 0, 0, 0, 0, 9, 0, 6'b100000));
      tbl.push_back(mk("r9_issue3",       1, 9, 4'h4, 0, 0, 0, 0, 0, 0, 9, 0, 6'b100000));
      tbl.push_back(mk("r9_saturate",     1, 9, 4'h8, 0, 0, 0, 0, 0, 0, 9, 0, 6'b100001));
      tbl.push_back(mk("r9_retire1",      0, 0, 4'h0, 0, 0, 1, 9, 0, 0, 9, 0, 6'b100001));
      tbl.push_back(mk("r9_retire2",      0, 0, 4'h0, 0, 0, 1, 9, 0, 0, 9, 0, 6'b100001));
      tbl.push_back(mk("r9_retire3",      0, 0, 4'h0, 0, 0, 1, 9, 0, 0, 9, 0, 6'b000001));
      tbl.push_back(mk("load_r10",        1, 10, 4'hF, 1, 0, 0, 0, 0, 0, 10, 0, 6'b110001));
      tbl.push_back(mk("iss11_ret10",     1, 11, 4'hF, 0, 0, 1, 10, 0, 0, 10, 11, 6'b001001));
      tbl.push_back(mk("div_r4",          1, 4, 4'hF, 0, 1, 0, 0, 0, 0, 4, 11, 6'b101011));
      tbl.push_back(mk("flush_iss_r6",    1, 6, 4'hF, 0, 0, 0, 0, 0, 1, 6, 4, 6'b000001));
      tbl.push_back(mk("div_set_wins",    1, 2, 4'hF, 0, 1, 0, 0, 1, 0, 2, 0, 6'b100011));
      tbl.push_back(mk("div_done",        0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 2, 0, 6'b100001));
      tbl.push_back(mk("flush_ret_r2",    0, 0, 4'h0, 0, 0, 1, 2, 0, 1, 2, 0, 6'b000001));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      sbq.push_back('{name: "reset_state", exp: 6'b000000});
      check_now();
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Asynchronous reset between edges clears state before the next edge.
      apply(mk("pre_async_r12", 1, 12, 4'hF, 1, 1, 0, 0, 0, 0, 12, 12, 6'b111111));
      #2;
      rst = 1'b1;
      #1;
      sbq.push_back('{name: "async_reset", exp: 6'b000000});
      check_now();
      @(negedge clk);
      rst = 1'b0;

      // Underflow from a clean state.
      apply(mk("underflow_r1", 0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 1, 0, 6'b000001));

      if (sbq.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_leftover got=%0d required=0", sbq.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule
